// File: rtl/ela_pkg.sv
// Shared constants, state encoding and tag helper for the ELA frame reader.
package ela_pkg;

    localparam int unsigned IMG_W     = 32;
    localparam int unsigned IMG_H     = 32;
    localparam int unsigned LAST_ADDR = 1023;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned PTR_W     = ADDR_W + 1;
    localparam int unsigned COL_W     = 5;
    localparam int unsigned TAG_W     = 3;
    localparam int unsigned PAYLOAD_W = PIX_W + TAG_W;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StFin
    } reader_state_e;

    typedef struct packed {
        logic sol;
        logic eol;
        logic eof;
    } pix_tag_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        pix_tag_t         tag;
    } pixel_t;

    // Row/frame markers derived from a row-major read address.
    function automatic pix_tag_t addr_tag(input logic [ADDR_W-1:0] addr);
        pix_tag_t t;
        t.sol = (addr[COL_W-1:0] == '0);
        t.eol = (addr[COL_W-1:0] == COL_W'(IMG_W - 1));
        t.eof = (addr == ADDR_W'(LAST_ADDR));
        return t;
    endfunction

endpackage

// File: rtl/ela_reader_if.sv
// Frame-reader bus: start/done control, memory read port and tagged pixel stream.
interface ela_reader_if;
    import ela_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] addr;
    logic              ren;
    logic [PIX_W-1:0]  data_rd;
    logic              out_valid;
    logic              out_ready;
    logic [PIX_W-1:0]  out_data;
    logic              out_sol;
    logic              out_eol;
    logic              out_eof;
    logic              busy;
    logic              done;

    modport master (
        input  start,
        input  data_rd,
        input  out_ready,
        output addr,
        output ren,
        output out_valid,
        output out_data,
        output out_sol,
        output out_eol,
        output out_eof,
        output busy,
        output done
    );

    modport slave (
        output start,
        output data_rd,
        output out_ready,
        input  addr,
        input  ren,
        input  out_valid,
        input  out_data,
        input  out_sol,
        input  out_eol,
        input  out_eof,
        input  busy,
        input  done
    );

endinterface

// File: rtl/ela_skid_fifo.sv
// Two-entry FIFO holding pixels plus tags between the memory return path and the stream.
module ela_skid_fifo
    import ela_pkg::*;
#(
    parameter int unsigned Width = PAYLOAD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign empty  = (count_q == 2'd0);
    assign full   = (count_q == 2'd2);
    assign do_pop = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ela_reader.sv
// Streams a 32x32 frame out of a read-latency-1 memory as a tagged valid/ready
// pixel stream, keeping at most two pixels stored or in flight.
module ela_reader
    import ela_pkg::*;
(
    input logic          clk,
    input logic          rst,
    ela_reader_if.master bus
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LAST_ADDR);

    reader_state_e    state_q;
    logic [PTR_W-1:0] ptr_q;
    logic             inflight_q;
    pix_tag_t         inflight_tag_q;
    logic             busy_q;
    logic             done_q;

    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] fifo_count;
    logic       pop;
    logic       issue;
    logic [2:0] occupancy;
    pixel_t     fifo_din;
    pixel_t     head;
    logic       unused_fifo_full;

    assign pop = !fifo_empty && bus.out_ready;
    // Slots committed after this edge: stored pixels plus the returning read, minus a pop.
    assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == StRun) && (ptr_q <= LAST_PTR) && (occupancy < 3'd2);
    assign fifo_din  = '{data: bus.data_rd, tag: inflight_tag_q};
    assign unused_fifo_full = fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            ptr_q          <= '0;
            inflight_q     <= 1'b0;
            inflight_tag_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_tag_q <= addr_tag(ptr_q[ADDR_W-1:0]);
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StRun;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    if (issue) begin
                        ptr_q <= ptr_q + PTR_W'(1);
                        if (ptr_q == LAST_PTR) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (pop && head.tag.eof) begin
                        state_q <= StFin;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StFin: begin
                    // Level-sensitive start: wait for it to drop before rearming.
                    if (!bus.start) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    ela_skid_fifo #(
        .Width(PAYLOAD_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_q),
        .pop  (pop),
        .din  (fifo_din),
        .dout (head),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign bus.ren       = issue;
    assign bus.addr      = ptr_q[ADDR_W-1:0];
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = head.data;
    assign bus.out_sol   = head.tag.sol;
    assign bus.out_eol   = head.tag.eol;
    assign bus.out_eof   = head.tag.eof;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_ela_reader.sv
// Self-checking bench for ela_reader: start-up vector table, full frames under
// random backpressure against a frame-level pixel model, reset and restart cases.
module tb_ela_reader;
    import ela_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ela_reader_if bus ();

    ela_reader dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [PIX_W-1:0] mem [1024];
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory answers one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.ren) bus.data_rd <= mem[bus.addr];
    end

    int checks;
    int errors;

    // Frame-level stream model state.
    int          issued;
    int          accepted;
    int          first_valid_cyc;
    int          done_cyc;
    int          start_cyc;
    bit          eof_prev;
    bit          prev_stall;
    logic [10:0] prev_payload;

    typedef struct {
        logic       start;
        logic       ready;
        logic       ren;
        logic [9:0] addr;
        logic       valid;
        logic [7:0] data;
        logic       sol;
        logic       busy;
        logic       done;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] exp_payload(input int k);
        return {mem[k], (k % IMG_W) == 0, (k % IMG_W) == IMG_W - 1, k == 1023};
    endfunction

    task automatic mon_clear();
        issued          = 0;
        accepted        = 0;
        first_valid_cyc = -1;
        done_cyc        = -1;
        eof_prev        = 1'b0;
        prev_stall      = 1'b0;
        prev_payload    = '0;
    endtask

    task automatic monitor_sample();
        logic [10:0] act;
        act = {bus.out_data, bus.out_sol, bus.out_eol, bus.out_eof};
        if (rst) begin
            mon_clear();
            return;
        end
        if (eof_prev) begin
            check("done_after_eof", 32'({bus.done, bus.busy}), 32'd2);
            done_cyc = cyc;
        end
        eof_prev = 1'b0;
        if (prev_stall) check("stall_hold", 32'({bus.out_valid, act}), 32'({1'b1, prev_payload}));
        check("occupancy", 32'((issued - accepted) <= 2), 32'd1);
        if (bus.ren) begin
            check("ren_busy", 32'(bus.busy), 32'd1);
            check("read_addr", 32'(bus.addr), 32'(issued));
            issued++;
        end
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.out_valid && bus.out_ready) begin
            if (accepted < 1024) begin
                check($sformatf("pixel%0d", accepted), 32'(act), 32'(exp_payload(accepted)));
                if (accepted == 1023) eof_prev = 1'b1;
            end else begin
                check("extra_pixel", 32'(accepted), 32'd1023);
            end
            accepted++;
        end
        prev_stall   = bus.out_valid && !bus.out_ready;
        prev_payload = act;
    endtask

    task automatic to_negedge();
        @(negedge clk);
        monitor_sample();
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({bus.ren, bus.addr, bus.out_valid, bus.out_data, bus.out_sol,
                         bus.out_eol, bus.out_eof, bus.busy, bus.done}), 32'd0);
    endtask

    task automatic pulse_reset();
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        to_negedge();
        to_drive();
        rst = 1'b0;
    endtask

    task automatic run_frame(input int duty, input int stop_at);
        bit timed_out;
        mon_clear();
        bus.start = 1'b1;
        start_cyc = cyc + 1;
        timed_out = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            bus.out_ready = ($urandom_range(0, 99) < duty);
            to_negedge();
            if (done_cyc >= 0 || accepted > stop_at) begin
                timed_out = 1'b0;
                to_drive();
                break;
            end
            to_drive();
        end
        check("frame_timeout", 32'(timed_out), 32'd0);
    endtask

    task automatic check_full_frame(input string name);
        check({name, "_pixels"}, 32'(accepted), 32'd1024);
        check({name, "_reads"}, 32'(issued), 32'd1024);
    endtask

    task automatic drop_start();
        bus.start = 1'b0;
        to_negedge();
        to_drive();
        to_negedge();
        check("idle_after_drop", 32'({bus.done, bus.busy}), 32'd0);
        to_drive();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i % 256);
        mon_clear();

        // start, ready -> ren, addr, valid, data, sol, busy, done
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 10'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 10'd1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        for (int i = 4; i < 12; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, 10'd2, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 10'd2, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 10'd3, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 10'd3, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 10'd4, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 10'd5, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst = 1'b0;

        // Start-up latency and early backpressure, cycle by cycle.
        for (int i = 0; i < NV; i++) begin
            bus.start     = vecs[i].start;
            bus.out_ready = vecs[i].ready;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  32'({bus.ren, bus.addr, bus.out_valid, bus.out_data, bus.out_sol, bus.busy,
                       bus.done}),
                  32'({vecs[i].ren, vecs[i].addr, vecs[i].valid, vecs[i].data, vecs[i].sol,
                       vecs[i].busy, vecs[i].done}));
            monitor_sample();
            to_drive();
        end
        pulse_reset();

        // Full frame at full throughput.
        run_frame(100, 2000);
        check_full_frame("frame_full");
        check("first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'd2);
        check("frame_length", 32'(done_cyc - first_valid_cyc), 32'd1024);

        // Start held high must not retrigger.
        for (int i = 0; i < 10; i++) begin
            to_negedge();
            check("hold_start", 32'({bus.done, bus.busy, bus.ren, bus.out_valid}), 32'd8);
            to_drive();
        end
        drop_start();

        // Random contents, 30% ready duty.
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        run_frame(30, 2000);
        check_full_frame("frame_bp");
        drop_start();

        // Asynchronous reset mid-frame, then a clean restart.
        run_frame(70, 500);
        check("mid_accepted", 32'(accepted), 32'd501);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        bus.start = 1'b0;
        to_negedge();
        to_drive();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            to_negedge();
            check("post_reset_quiet",
                  32'({bus.out_valid, bus.busy, bus.done, bus.ren}), 32'd0);
            to_drive();
        end
        run_frame(100, 2000);
        check_full_frame("frame_restart");
        check("restart_latency", 32'(first_valid_cyc - start_cyc), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ela_reader.md
ELA_READER -- requirements
Module: ela_reader

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: start  in  1  level; frame ready in memory (driven from ELA done).
REQ-004 SHALL have: addr  out  10  memory read address, row-major (row*32+col).
REQ-005 SHALL have: ren  out  1  read strobe; memory returns data_rd exactly 1 cycle after ren=1.
REQ-006 SHALL have: data_rd  in  8  memory read data.
REQ-007 SHALL have: out_valid  out  1; out_ready  in  1; out_data  out  8  pixel stream; transfer when both high at a rising edge.
REQ-008 SHALL have: out_sol, out_eol, out_eof  out  1 each  qualified by out_valid: col 0, col 31, pixel 1023.
REQ-009 SHALL have: busy  out  1; done  out  1  frame fully transferred.

Function
REQ-010 SHALL implement FSM IDLE -> RUN -> DRAIN -> FIN -> IDLE.
REQ-011 IDLE: start=1 at a rising edge SHALL move to RUN; read pointer cleared to 0.
REQ-012 RUN: ren SHALL assert, addr=read pointer, when pointer<=1023 and (fifo_count + inflight - pop) < 2; pointer increments per issued read.
REQ-013 RUN SHALL move to DRAIN the edge the read of address 1023 is issued.
REQ-014 DRAIN SHALL issue no reads and SHALL move to FIN on the handshake of the pixel tagged out_eof.
REQ-015 FIN SHALL hold done=1; SHALL return to IDLE (done=0) only when start=0; start held high SHALL NOT retrigger a frame.
REQ-016 Returned data SHALL enter a 2-entry FIFO with tags (sol, eol, eof) computed from the issued address (addr[4:0]==0, addr[4:0]==31, addr==1023), delayed one cycle with the data.
REQ-017 out_valid SHALL equal FIFO non-empty; out_data/tags SHALL be FIFO head and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-018 Latency: start sampled at edge n -> ren=1, addr=0 in cycle n+1 -> out_valid=1 with pixel 0 from edge n+2.
REQ-019 Throughput: with out_ready held 1, one pixel per cycle; frame completes 1024 cycles after first out_valid; done asserts the edge after the eof handshake.
REQ-020 Backpressure: FIFO SHALL never overflow, including when out_ready drops while a read is in flight; no pixel dropped or duplicated.
REQ-021 Simultaneous push and pop on a full FIFO SHALL be legal and keep count at 2.
REQ-022 busy SHALL be 1 in RUN and DRAIN, 0 otherwise; ren SHALL be 0 outside RUN.
REQ-023 Read pointer SHALL be 11 bits so 1024 terminates without wrapping to 0.

Reset
REQ-024 rst=1 SHALL force, asynchronously: state IDLE, pointer 0, FIFO empty, inflight 0, ren 0, addr 0, out_valid 0, out_data 0, tags 0, busy 0, done 0.
REQ-025 Reset mid-frame SHALL discard any in-flight read; data_rd arriving the cycle after reset release SHALL NOT enter the FIFO.

Structure
REQ-026 Package ela_pkg SHALL hold IMG_W=32, IMG_H=32, LAST_ADDR=1023, ADDR_W=10, PIX_W=8, and the reader state enum.
REQ-027 FIFO SHALL be sub-module ela_skid_fifo (2 entries, 11-bit payload: data+3 tags, push/pop/count/full/empty).

Verification
REQ-028 Memory preloaded mem[i]=i%256, start=1, out_ready=1 -> 1024 pixels, pixel k=k%256, first out_valid 2 cycles after start edge, done 1 cycle after eof.
REQ-029 Tags: check out_sol on pixels 0,32,...,992; out_eol on 31,63,...,1023; out_eof only on 1023.
REQ-030 out_ready random 30% duty -> identical sequence, out_data stable while stalled, FIFO count never >2.
REQ-031 out_ready=0 for 10 cycles right after first ren -> exactly 2 reads issued, ren then 0 until a pop.
REQ-032 rst pulsed after pixel 500 -> all outputs at reset values immediately; re-start yields full frame from pixel 0.
REQ-033 start held high after done -> no second frame; drop start -> IDLE, done=0; raise start -> new frame.
